ram: RTL and testbench
======================

// Module: ram
// PURPOSE
//  Word-organised data memory for the sopc, serving the MEM stage's load/store port.
//  Uses a request/ready handshake with a configurable number of wait states, so the
//  pipeline stall path can be exercised.
//  Big-endian byte lanes, matching MIPS: byte address offset 0 maps to bits [31:24].
//  Instantiated in sopc beside rom; driven by stage_mem through the CPU data port.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits (depth = 2**ADDR_WIDTH words)
//  WAIT_CYCLES  0   extra cycles between request acceptance and ready (0..15)
// PORTS
//  clock         in   1   single clock; all state updates on rising edge
//  reset         in   1   asynchronous, active-high reset
//  enable        in   1   request valid; held high until ready is seen
//  write_enable  in   1   1 = store, 0 = load; sampled with enable
//  address       in   32  byte address; bits [ADDR_WIDTH+1:2] index the word
//  select        in   4   byte-lane enables for stores; [3]=bits 31:24 .. [0]=bits 7:0
//  write_data    in   32  store data, already lane-aligned by stage_mem
//  read_data     out  32  full word read; valid only while ready=1
//  ready         out  1   one-cycle pulse: access complete
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, ready=0, read_data=0.
//    Memory array contents are NOT cleared.
//  - FSM states: IDLE, WAIT, ACK.
//    IDLE: if enable=1, latch write_enable/address/select/write_data into request regs.
//          Next state is WAIT if WAIT_CYCLES>0, else ACK. Counter loads WAIT_CYCLES-1.
//    WAIT: counter decrements each cycle; at 0 -> ACK. If enable=0 -> IDLE (abort).
//    ACK:  ready=1 for exactly this cycle.
//          Load: read_data = mem[latched word index].
//          Store: masked write of the latched lanes at this edge.
//          Next state is always IDLE.
//  - Latency: request accepted at edge N; ready high in cycle N+1+WAIT_CYCLES.
//    Minimum back-to-back rate: one access every WAIT_CYCLES+2 cycles.
//  - Requester holds inputs stable until ready. The RAM uses the latched copy, so
//    input changes after acceptance are ignored.
//  - read_data is registered at the ACK transition, returns 32'h0 outside ACK, and
//    ignores select (lane extraction and sign extension belong to stage_mem).
//  - Store in ACK: only lanes with select[i]=1 change; select=4'b0000 writes nothing.
//    read_data for a store is 32'h0.
//  - Address handling:
//    - Address bits above ADDR_WIDTH+1 are ignored (address wraps modulo depth).
//    - address[1:0] are ignored; alignment is stage_mem's job.
//  - Abort: enable deasserted in WAIT returns the FSM to IDLE with no write and no ready.
//    In ACK the access completes regardless of enable.
//  - Reset mid-access (WAIT or ACK before the edge): the access is dropped, no write
//    occurs, and ready falls immediately.
//  - An enable held high after ready is treated as a new request in the next IDLE cycle.
// TESTING
//  1. WAIT_CYCLES=0: store 32'hDEADBEEF, select=4'hF @0x10, then load 0x10.
//     -> ready 1 cycle after each acceptance; read_data=32'hDEADBEEF.
//  2. Byte lanes: preload 0x20=32'h11223344; store write_data=32'hAA000000, select=4'b1000;
//     then store 32'h000000BB, select=4'b0001.
//     -> load 0x20 returns 32'hAA2233BB.
//  3. WAIT_CYCLES=3: load accepted at edge N.
//     -> ready high only in cycle N+4; ready=0 and read_data=0 in cycles N+1..N+3.
//  4. Wrap: ADDR_WIDTH=10; store 32'h12345678 @0x1000; load 0x0000 -> 32'h12345678.
//     Load 0x0003 -> same word.
//  5. Abort/reset: WAIT_CYCLES=3; drop enable in WAIT during a store -> no ready, word unchanged.
//     Repeat with reset pulsed mid-WAIT -> ready=0 at once, FSM in IDLE, word unchanged.
//  6. Back-to-back: enable held high across 3 loads with WAIT_CYCLES=0.
//     -> ready pulses every 2 cycles; data correct for each address.

Source files
------------

// File: rtl/ram_if.sv
// Load/store port between the MEM stage and the data RAM.
// Request fields are held by the master until ready pulses.
interface ram_if;
    logic        enable;
    logic        write_enable;
    logic [31:0] address;
    logic [3:0]  select;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output enable,
        output write_enable,
        output address,
        output select,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  enable,
        input  write_enable,
        input  address,
        input  select,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/ram.sv
// Word-organised big-endian data RAM with a request/ready handshake.
// WAIT_CYCLES extra cycles sit between acceptance and the one-cycle ready pulse.
module ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic  clock,
    input logic  reset,
    ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t                  state;
    logic [3:0]              cnt;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [3:0]              req_sel;
    logic [31:0]             req_wd;
    logic                    ready_q;
    logic [31:0]             rdata_q;

    logic [ADDR_WIDTH-1:0]   in_idx;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    rd_we;
    logic                    go_ack;
    logic                    addr_unused;

    // High address bits wrap and the byte offset is the MEM stage's concern.
    assign in_idx      = bus.address[ADDR_WIDTH+1:2];
    assign addr_unused = ^{bus.address[31:ADDR_WIDTH+2], bus.address[1:0]};

    assign bus.ready     = ready_q;
    assign bus.read_data = rdata_q;

    // Decide whether ACK is entered at the coming edge and which word to read.
    always_comb begin
        go_ack = 1'b0;
        rd_idx = req_idx;
        rd_we  = req_we;
        unique case (state)
            S_IDLE: begin
                go_ack = bus.enable && (WAIT_CYCLES == 0);
                rd_idx = in_idx;
                rd_we  = bus.write_enable;
            end
            S_WAIT: begin
                go_ack = bus.enable && (cnt == 4'd0);
            end
            default: begin
                go_ack = 1'b0;
            end
        endcase
    end

    // Handshake FSM, request capture and registered ready/read_data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            req_we  <= 1'b0;
            req_idx <= '0;
            req_sel <= 4'd0;
            req_wd  <= 32'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= go_ack;
            rdata_q <= (go_ack && !rd_we) ? mem[rd_idx] : 32'd0;
            unique case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        req_we  <= bus.write_enable;
                        req_idx <= in_idx;
                        req_sel <= bus.select;
                        req_wd  <= bus.write_data;
                        cnt     <= CNT_INIT;
                        state   <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.enable) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Masked store commits on the edge that closes ACK; the array has no reset.
    always_ff @(posedge clock) begin
        if (state == S_ACK && req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_sel[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wd[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: two instances, zero and three wait states.
// Drivers push expected read_data; negedge monitors pop on each ready.
module tb_ram;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ram_if b0 ();
    ram_if b3 ();

    ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
        .clock(clock),
        .reset(reset),
        .bus  (b0)
    );

    ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (
        .clock(clock),
        .reset(reset),
        .bus  (b3)
    );

    logic        en [2];
    logic        we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  sl [2];
    logic        rdy [2];
    logic [31:0] rdat [2];

    assign b0.enable       = en[0];
    assign b0.write_enable = we[0];
    assign b0.address      = ad[0];
    assign b0.select       = sl[0];
    assign b0.write_data   = wd[0];
    assign b3.enable       = en[1];
    assign b3.write_enable = we[1];
    assign b3.address      = ad[1];
    assign b3.select       = sl[1];
    assign b3.write_data   = wd[1];
    assign rdy[0]  = b0.ready;
    assign rdy[1]  = b3.ready;
    assign rdat[0] = b0.read_data;
    assign rdat[1] = b3.read_data;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: every ready pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (b0.ready === 1'b1) begin
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready_w0: got ready=1 expected none at %0t", $time);
            end else begin
                chk("data_w0", b0.read_data, q0.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (b3.ready === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready_w3: got ready=1 expected none at %0t", $time);
            end else begin
                chk("data_w3", b3.read_data, q1.pop_front());
            end
        end
    end

    // One access; called #1 after a posedge with the target FSM idle.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] data,
                          input logic [31:0] exp, input int lat,
                          input bit hold);
        int n;
        we[d] = w;
        ad[d] = a;
        sl[d] = s;
        wd[d] = data;
        en[d] = 1'b1;
        if (d == 0) q0.push_back(exp);
        else        q1.push_back(exp);
        @(posedge clock);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (!rdy[d]) chk("rd_zero_before_ready", rdat[d], 32'h0);
        end while (!rdy[d] && n < lat + 8);
        chk("latency", 32'(n), 32'(lat));
        @(posedge clock);
        #1;
        if (!hold) en[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0;
            we[i] = 1'b0;
            ad[i] = 32'h0;
            wd[i] = 32'h0;
            sl[i] = 4'h0;
        end
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ready_w0", 32'(b0.ready), 32'h0);
        chk("reset_rd_w0", b0.read_data, 32'h0);
        chk("reset_ready_w3", 32'(b3.ready), 32'h0);
        chk("reset_rd_w3", b3.read_data, 32'h0);
        reset = 1'b0;
        idle_cycles(1);

        // Full-word store then load, zero wait states
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1, 1'b0);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1, 1'b0);

        // Byte lanes, big-endian
        access(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1, 1'b0);
        access(0, 1'b1, 32'h20, 4'b1000, 32'hAA000000, 32'h0, 1, 1'b0);
        access(0, 1'b1, 32'h20, 4'b0001, 32'h000000BB, 32'h0, 1, 1'b0);
        access(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'hAA2233BB, 1, 1'b0);
        access(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, 1, 1'b0);
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hAA2233BB, 1, 1'b0);

        // Address wrap and ignored byte offset
        access(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1, 1'b0);
        access(0, 1'b0, 32'h0000, 4'hF, 32'h0, 32'h12345678, 1, 1'b0);
        access(0, 1'b0, 32'h0003, 4'hF, 32'h0, 32'h12345678, 1, 1'b0);

        // Back-to-back loads with enable held high
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1, 1'b1);
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hAA2233BB, 1, 1'b1);
        access(0, 1'b0, 32'h00, 4'hF, 32'h0, 32'h12345678, 1, 1'b0);
        idle_cycles(2);

        // Three wait states: preload, then timed load
        access(1, 1'b1, 32'h40, 4'hF, 32'h55667788, 32'h0, 4, 1'b0);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55667788, 4, 1'b0);

        // Abort a store by dropping enable in WAIT
        we[1] = 1'b1;
        ad[1] = 32'h40;
        sl[1] = 4'hF;
        wd[1] = 32'hAAAAAAAA;
        en[1] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        en[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("abort_no_ready", 32'(b3.ready), 32'h0);
        end
        idle_cycles(1);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55667788, 4, 1'b0);

        // Reset pulsed mid-WAIT during a store
        we[1] = 1'b1;
        wd[1] = 32'hBBBBBBBB;
        en[1] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_wait_ready", 32'(b3.ready), 32'h0);
        en[1] = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_cycles(1);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55667788, 4, 1'b0);

        // Reset pulsed during ACK of a store
        we[1] = 1'b1;
        wd[1] = 32'hCCCCCCCC;
        en[1] = 1'b1;
        q1.push_back(32'h0);
        @(posedge clock);
        repeat (4) @(negedge clock);
        chk("ack_before_rst", 32'(b3.ready), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_ack_ready", 32'(b3.ready), 32'h0);
        chk("rst_ack_rd", b3.read_data, 32'h0);
        en[1] = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_cycles(1);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h55667788, 4, 1'b0);

        // Zero-wait instance kept its contents across reset
        access(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'hAA2233BB, 1, 1'b0);

        idle_cycles(4);
        chk("q_w0_drained", 32'(q0.size()), 32'h0);
        chk("q_w3_drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
